// File: rtl/fancy_timer_ctrl.sv
// Programmable-delay timer controller: hunts for a start pattern, shifts in a
// delay MSB-first, counts (delay+1)*TICKS_PER_UNIT cycles, then holds done until ack.
module fancy_timer_ctrl #(
  parameter logic [3:0] PATTERN        = 4'b1101,
  parameter int         DELAY_W        = 4,
  parameter int         TICKS_PER_UNIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done
);

  localparam int TICK_W = $clog2(TICKS_PER_UNIT);
  localparam int BIT_W  = $clog2(DELAY_W + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_W - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          hist_q, hist_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [DELAY_W-1:0]  count_q, count_d;
  logic                counting_q, counting_d;
  logic                done_q, done_d;

  // Only the three most recent bits are kept; the fourth is the live data input.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
    delay_d = delay_q;
    case (state_q)
      SEARCH: begin
        hist_d = {hist_q[1:0], data};
        if ({hist_q, data} == PATTERN) begin
          state_d = SHIFT;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        delay_d = {delay_q[DELAY_W-2:0], data};
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          state_d = COUNT;
          tick_d  = '0;
        end
      end
      COUNT: begin
        if (tick_q == TICK_LAST) begin
          if (delay_q == '0) begin
            state_d = DONE;
          end else begin
            delay_d = delay_q - 1'b1;
            tick_d  = '0;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = SEARCH;
          hist_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase

    // Outputs are decoded from the next state so the registered copies track state_q exactly.
    counting_d = (state_d == COUNT);
    done_d     = (state_d == DONE);
    count_d    = (state_d == COUNT) ? delay_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      hist_q     <= '0;
      bit_q      <= '0;
      tick_q     <= '0;
      delay_q    <= '0;
      count_q    <= '0;
      counting_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      bit_q      <= bit_d;
      tick_q     <= tick_d;
      delay_q    <= delay_d;
      count_q    <= count_d;
      counting_q <= counting_d;
      done_q     <= done_d;
    end
  end

  assign count    = count_q;
  assign counting = counting_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fancy_timer_ctrl.sv
// Scoreboard bench for fancy_timer_ctrl: instance 0 uses default ticks,
// instance 1 uses TICKS_PER_UNIT=2.
module tb_fancy_timer_ctrl;

  localparam int DELAY_W = 4;

  typedef struct {
    int start;
    int delay;
    int len;
    bit exp_done;
  } run_t;

  logic               clk = 1'b0;
  logic [1:0]         reset_v = 2'b11;
  logic [1:0]         data_v = 2'b00;
  logic [1:0]         ack_v = 2'b00;
  logic [DELAY_W-1:0] count_v [2];
  logic [1:0]         counting_v;
  logic [1:0]         done_v;
  logic [1:0]         rst_seen = 2'b00;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  run_t run_q0[$];
  run_t run_q1[$];
  int   dfall_q0[$];
  int   dfall_q1[$];

  always #5 clk = ~clk;

  fancy_timer_ctrl u_dut0 (
    .clk(clk), .reset(reset_v[0]), .data(data_v[0]), .ack(ack_v[0]),
    .count(count_v[0]), .counting(counting_v[0]), .done(done_v[0])
  );

  fancy_timer_ctrl #(.TICKS_PER_UNIT(2)) u_dut1 (
    .clk(clk), .reset(reset_v[1]), .data(data_v[1]), .ack(ack_v[1]),
    .count(count_v[1]), .counting(counting_v[1]), .done(done_v[1])
  );

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset_v;
  end

  // Monitor: pops expectations when the DUT starts/ends a count run or drops done.
  logic [1:0] prev_cnt = 2'b00;
  logic [1:0] prev_done = 2'b00;
  logic [1:0] in_run = 2'b00;
  logic [1:0] bad = 2'b00;
  run_t cur [2];
  int   base [2];
  int   bad_idx [2];
  int   bad_act [2];
  int   bad_exp [2];
  int   idx, exp_c, tpu, exp_fall;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      tpu = (i == 0) ? 1000 : 2;
      if (rst_seen[i[0]]) begin
        n_checks++;
        if (counting_v[i[0]] || done_v[i[0]] || count_v[i[0]] != '0) begin
          n_fail++;
          $display("FAIL reset_outputs inst%0d: counting=%0b done=%0b count=%0d, required 0 0 0",
                   i, counting_v[i[0]], done_v[i[0]], count_v[i[0]]);
        end
      end
      if (counting_v[i[0]] && !prev_cnt[i[0]]) begin
        n_checks++;
        if ((i == 0 && run_q0.size() == 0) || (i == 1 && run_q1.size() == 0)) begin
          n_fail++;
          in_run[i[0]] = 1'b0;
          $display("FAIL unexpected_start inst%0d: counting rose at cycle %0d, required no run", i, cyc);
        end else begin
          cur[i[0]] = (i == 0) ? run_q0.pop_front() : run_q1.pop_front();
          in_run[i[0]] = 1'b1;
          bad[i[0]] = 1'b0;
          base[i[0]] = cyc;
          n_checks++;
          if (cyc != cur[i[0]].start) begin
            n_fail++;
            $display("FAIL start_cycle inst%0d: counting rose at %0d, required %0d", i, cyc, cur[i[0]].start);
          end
        end
      end
      if (counting_v[i[0]] && in_run[i[0]]) begin
        idx = cyc - base[i[0]];
        exp_c = cur[i[0]].delay - idx / tpu;
        if (!bad[i[0]] && int'(count_v[i[0]]) != exp_c) begin
          bad[i[0]] = 1'b1;
          bad_idx[i[0]] = idx;
          bad_act[i[0]] = int'(count_v[i[0]]);
          bad_exp[i[0]] = exp_c;
        end
      end
      if (!counting_v[i[0]] && prev_cnt[i[0]] && in_run[i[0]]) begin
        in_run[i[0]] = 1'b0;
        n_checks += 4;
        if (cyc - base[i[0]] != cur[i[0]].len) begin
          n_fail++;
          $display("FAIL run_len inst%0d: counting high %0d cycles, required %0d",
                   i, cyc - base[i[0]], cur[i[0]].len);
        end
        if (done_v[i[0]] != cur[i[0]].exp_done) begin
          n_fail++;
          $display("FAIL done_after_run inst%0d: done=%0b, required %0b", i, done_v[i[0]], cur[i[0]].exp_done);
        end
        if (count_v[i[0]] != '0) begin
          n_fail++;
          $display("FAIL count_idle inst%0d: count=%0d, required 0", i, count_v[i[0]]);
        end
        if (bad[i[0]]) begin
          n_fail++;
          $display("FAIL count_trace inst%0d: at run cycle %0d count=%0d, required %0d",
                   i, bad_idx[i[0]], bad_act[i[0]], bad_exp[i[0]]);
        end
      end
      if (!done_v[i[0]] && prev_done[i[0]]) begin
        n_checks++;
        if ((i == 0 && dfall_q0.size() == 0) || (i == 1 && dfall_q1.size() == 0)) begin
          n_fail++;
          $display("FAIL unexpected_done_fall inst%0d: done fell at %0d, required still high", i, cyc);
        end else begin
          exp_fall = (i == 0) ? dfall_q0.pop_front() : dfall_q1.pop_front();
          if (cyc != exp_fall) begin
            n_fail++;
            $display("FAIL done_fall inst%0d: done fell at %0d, required %0d", i, cyc, exp_fall);
          end
        end
      end
      prev_cnt[i[0]]  = counting_v[i[0]];
      prev_done[i[0]] = done_v[i[0]];
    end
  end

  task automatic send_bits(input int inst, input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      @(negedge clk);
      data_v[inst[0]] = bits[k[3:0]];
    end
  endtask

  // Last bit is sampled on the next edge, so counting is first seen at cyc+1.
  task automatic start_run(input int inst, input logic [15:0] bits, input int n,
                           input int dly, input int len, input bit exp_done);
    run_t r;
    send_bits(inst, bits, n);
    r.start = cyc + 1;
    r.delay = dly;
    r.len = len;
    r.exp_done = exp_done;
    if (inst == 0) run_q0.push_back(r);
    else run_q1.push_back(r);
  endtask

  task automatic wait_done(input int inst, input int budget);
    int w = 0;
    while (!done_v[inst[0]] && w < budget) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (!done_v[inst[0]]) begin
      n_fail++;
      $display("FAIL done_timeout inst%0d: done=0 after %0d cycles, required 1", inst, budget);
    end
  endtask

  task automatic do_ack(input int inst, input int hold);
    repeat (hold) @(negedge clk);
    ack_v[inst[0]] = 1'b1;
    data_v[inst[0]] = 1'b0;
    if (inst == 0) dfall_q0.push_back(cyc + 1);
    else dfall_q1.push_back(cyc + 1);
    @(negedge clk);
    ack_v[inst[0]] = 1'b0;
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    reset_v[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Defaults: 1101 + delay 5
    start_run(0, 16'h00D5, 8, 5, 6000, 1'b1);
    wait_done(0, 7000);
    do_ack(0, 50);
    repeat (3) @(negedge clk);

    // Delay 0
    start_run(0, 16'h00D0, 8, 0, 1000, 1'b1);
    wait_done(0, 2000);
    do_ack(0, 3);
    repeat (3) @(negedge clk);

    // Overlapping match 11101 then delay 0010
    start_run(0, 16'h01D2, 9, 2, 3000, 1'b1);
    wait_done(0, 4000);
    do_ack(0, 1);
    repeat (3) @(negedge clk);

    // 11001101 matches only on the last bit, delay 0001
    start_run(0, 16'h0CD1, 12, 1, 2000, 1'b1);
    wait_done(0, 3000);
    do_ack(0, 1);
    repeat (3) @(negedge clk);

    // ack held through COUNT: run length unchanged, done lasts one cycle
    start_run(0, 16'h00D1, 8, 1, 2000, 1'b1);
    s = cyc + 1;
    ack_v[0] = 1'b1;
    dfall_q0.push_back(s + 2001);
    wait_done(0, 3000);
    @(negedge clk);
    ack_v[0] = 1'b0;
    data_v[0] = 1'b0;
    repeat (3) @(negedge clk);

    // 110 during DONE then 1 after ack must not match
    start_run(0, 16'h00D0, 8, 0, 1000, 1'b1);
    wait_done(0, 2000);
    send_bits(0, 16'h0006, 3);
    @(negedge clk);
    ack_v[0] = 1'b1;
    data_v[0] = 1'b0;
    dfall_q0.push_back(cyc + 1);
    @(negedge clk);
    ack_v[0] = 1'b0;
    data_v[0] = 1'b1;
    @(negedge clk);
    data_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    start_run(0, 16'h00D1, 8, 1, 2000, 1'b1);
    wait_done(0, 3000);
    do_ack(0, 2);
    repeat (3) @(negedge clk);

    // Reset mid-COUNT while count=3, then a fresh run
    start_run(0, 16'h00D5, 8, 5, 2501, 1'b0);
    repeat (2501) @(negedge clk);
    reset_v[0] = 1'b1;
    @(negedge clk);
    reset_v[0] = 1'b0;
    data_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_run(0, 16'h00D3, 8, 3, 4000, 1'b1);
    wait_done(0, 5000);
    do_ack(0, 2);

    // TICKS_PER_UNIT=2, delay 15
    @(negedge clk);
    reset_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    start_run(1, 16'h00DF, 8, 15, 32, 1'b1);
    wait_done(1, 100);
    do_ack(1, 2);

    repeat (5) @(negedge clk);
    n_checks += 4;
    if (run_q0.size() != 0 || run_q1.size() != 0) begin
      n_fail++;
      $display("FAIL runs_pending: %0d/%0d expected runs never seen, required 0/0", run_q0.size(), run_q1.size());
    end
    if (dfall_q0.size() != 0 || dfall_q1.size() != 0) begin
      n_fail++;
      $display("FAIL done_pending: %0d/%0d done falls never seen, required 0/0", dfall_q0.size(), dfall_q1.size());
    end
    if (in_run != 2'b00) begin
      n_fail++;
      $display("FAIL run_open: in_run=%b, required 00", in_run);
    end
    if (counting_v != 2'b00 || done_v != 2'b00) begin
      n_fail++;
      $display("FAIL final_idle: counting=%b done=%b, required 00 00", counting_v, done_v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
